// File: rtl/hvac_pkg.sv
// Shared definitions for the HVAC controller and actuator guard: state encodings and
// default equipment-protection timings.
package hvac_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_HEAT    = 3'd1;
  localparam state_t S_COOL    = 3'd2;
  localparam state_t S_OVERRUN = 3'd3;
  localparam state_t S_LOCKOUT = 3'd4;

  localparam int unsigned DEF_MIN_ON_CYCLES      = 8;
  localparam int unsigned DEF_FAN_OVERRUN_CYCLES = 4;
  localparam int unsigned DEF_MIN_OFF_CYCLES     = 6;
  localparam int unsigned DEF_CNT_W              = 8;

  function automatic logic is_run_state(state_t s);
    return (s == S_HEAT) || (s == S_COOL);
  endfunction

endpackage

// File: rtl/hvac_actuator_guard_cycle_timer.sv
// Saturating up-counter with synchronous clear; reached_o flags count >= target-1, i.e. the
// current cycle is the last one of a target-long dwell.
module cycle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] target_i,
  output logic             reached_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (!(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign reached_o = (count_q >= (target_i - 1'b1));

endmodule

// File: rtl/hvac_actuator_guard.sv
// Equipment-protection stage between the hysteresis controller and the actuator pins.
// Optional start counters are built when START_COUNTERS_EN is defined.
module hvac_actuator_guard
  import hvac_pkg::*;
#(
  parameter int unsigned MIN_ON_CYCLES      = DEF_MIN_ON_CYCLES,
  parameter int unsigned FAN_OVERRUN_CYCLES = DEF_FAN_OVERRUN_CYCLES,
  parameter int unsigned MIN_OFF_CYCLES     = DEF_MIN_OFF_CYCLES,
  parameter int unsigned CNT_W              = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       heat_req,
  input  logic       cool_req,
  output logic       heater_on,
  output logic       compressor_on,
  output logic       fan_on,
  output logic       lockout,
`ifdef START_COUNTERS_EN
  output logic [7:0] heat_starts,
  output logic [7:0] cool_starts,
`endif
  output logic       req_conflict
);

  localparam logic [CNT_W-1:0] MinOnT   = CNT_W'(MIN_ON_CYCLES);
  localparam logic [CNT_W-1:0] OverrunT = CNT_W'(FAN_OVERRUN_CYCLES);
  localparam logic [CNT_W-1:0] MinOffT  = CNT_W'(MIN_OFF_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] target;
  logic             reached;
  logic             timer_clear;
  logic             req_conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A run ends only after its minimum; a newly opposing request also ends it.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (heat_req && !cool_req) begin
          state_d = S_HEAT;
        end else if (cool_req && !heat_req) begin
          state_d = S_COOL;
        end
      end
      S_HEAT: begin
        if (reached && (!heat_req || cool_req)) state_d = S_OVERRUN;
      end
      S_COOL: begin
        if (reached && (!cool_req || heat_req)) state_d = S_OVERRUN;
      end
      S_OVERRUN: begin
        if (reached) state_d = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (reached) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    heater_on     = 1'b0;
    compressor_on = 1'b0;
    fan_on        = 1'b0;
    lockout       = 1'b0;
    unique case (state_q)
      S_HEAT: begin
        heater_on = 1'b1;
        fan_on    = 1'b1;
      end
      S_COOL: begin
        compressor_on = 1'b1;
        fan_on        = 1'b1;
      end
      S_OVERRUN: fan_on  = 1'b1;
      S_LOCKOUT: lockout = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    target = MinOnT;
    unique case (state_q)
      S_OVERRUN: target = OverrunT;
      S_LOCKOUT: target = MinOffT;
      default:   target = MinOnT;
    endcase
  end

  assign timer_clear = (state_d != state_q);

  cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timer_clear),
    .target_i (target),
    .reached_o(reached)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_conflict_q <= 1'b0;
    end else begin
      req_conflict_q <= heat_req & cool_req;
    end
  end

  assign req_conflict = req_conflict_q;

`ifdef START_COUNTERS_EN
  logic [7:0] heat_starts_q, cool_starts_q;
  logic       heat_start, cool_start;

  assign heat_start = !is_run_state(state_q) && (state_q == S_IDLE) && (state_d == S_HEAT);
  assign cool_start = !is_run_state(state_q) && (state_q == S_IDLE) && (state_d == S_COOL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      heat_starts_q <= '0;
      cool_starts_q <= '0;
    end else begin
      if (heat_start && !(&heat_starts_q)) heat_starts_q <= heat_starts_q + 8'd1;
      if (cool_start && !(&cool_starts_q)) cool_starts_q <= cool_starts_q + 8'd1;
    end
  end

  assign heat_starts = heat_starts_q;
  assign cool_starts = cool_starts_q;
`endif

endmodule

// File: tb/tb_hvac_actuator_guard.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a monitor pops and compares
// them one time unit after each rising edge.
module tb_hvac_actuator_guard;

  localparam logic [4:0] E_IDLE = 5'b00000;  // {heater, compressor, fan, lockout, conflict}
  localparam logic [4:0] E_HEAT = 5'b10100;
  localparam logic [4:0] E_COOL = 5'b01100;
  localparam logic [4:0] E_OVR  = 5'b00100;
  localparam logic [4:0] E_LCK  = 5'b00010;
  localparam logic [4:0] E_CON  = 5'b00001;

  logic clk, rst, heat_req, cool_req;
  logic heater_on, compressor_on, fan_on, lockout, req_conflict;
`ifdef START_COUNTERS_EN
  logic [7:0] heat_starts, cool_starts;
`endif

  int    n_tests = 0;
  int    n_fail  = 0;
  string cur_test = "init";
  logic [4:0] exp_q[$];

  hvac_actuator_guard dut (
    .clk          (clk),
    .rst          (rst),
    .heat_req     (heat_req),
    .cool_req     (cool_req),
    .heater_on    (heater_on),
    .compressor_on(compressor_on),
    .fan_on       (fan_on),
    .lockout      (lockout),
`ifdef START_COUNTERS_EN
    .heat_starts  (heat_starts),
    .cool_starts  (cool_starts),
`endif
    .req_conflict (req_conflict)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] outs();
    return {heater_on, compressor_on, fan_on, lockout, req_conflict};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %b expected %b at %0t", cur_test, name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", outs(), e);
        check("exclusive", {4'b0, heater_on & compressor_on}, 5'b0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic h, input logic c, input logic [4:0] e);
    @(negedge clk);
    heat_req = h;
    cool_req = c;
    exp_q.push_back(e);
  endtask

  task automatic run(input logic h, input logic c, input logic [4:0] e, input int n);
    for (int i = 0; i < n; i++) cyc(h, c, e);
  endtask

  // Finish a run with requests released: remaining on-cycles, overrun, lockout, idle.
  task automatic finish_run(input logic [4:0] on_code, input int remaining);
    run(1'b0, 1'b0, on_code, remaining);
    run(1'b0, 1'b0, E_OVR, 4);
    run(1'b0, 1'b0, E_LCK, 6);
    run(1'b0, 1'b0, E_IDLE, 1);
  endtask

  initial begin
    rst      = 1'b1;
    heat_req = 1'b0;
    cool_req = 1'b0;
    #12;
    cur_test = "reset";
    check("reset_outputs", outs(), E_IDLE);
    @(negedge clk);
    rst = 1'b0;
    run(1'b0, 1'b0, E_IDLE, 2);

    cur_test = "heat_long";
    run(1'b1, 1'b0, E_HEAT, 20);
    finish_run(E_HEAT, 0);

    cur_test = "heat_pulse";
    run(1'b1, 1'b0, E_HEAT, 2);
    finish_run(E_HEAT, 6);

    cur_test = "cool_relock";
    run(1'b0, 1'b1, E_COOL, 10);
    run(1'b0, 1'b0, E_OVR, 4);
    run(1'b0, 1'b0, E_LCK, 3);
    run(1'b0, 1'b1, E_LCK, 3);
    cyc(1'b0, 1'b1, E_IDLE);
    cyc(1'b0, 1'b1, E_COOL);
    finish_run(E_COOL, 7);

    cur_test = "changeover";
    run(1'b1, 1'b0, E_HEAT, 10);
    run(1'b0, 1'b1, E_OVR, 4);
    run(1'b0, 1'b1, E_LCK, 6);
    cyc(1'b0, 1'b1, E_IDLE);
    cyc(1'b0, 1'b1, E_COOL);
    finish_run(E_COOL, 7);

    cur_test = "conflict_idle";
    run(1'b1, 1'b1, E_IDLE | E_CON, 3);
    run(1'b0, 1'b0, E_IDLE, 2);

    cur_test = "conflict_heat";
    run(1'b1, 1'b0, E_HEAT, 2);
    run(1'b1, 1'b1, E_HEAT | E_CON, 2);
    run(1'b1, 1'b0, E_HEAT, 5);
    cyc(1'b1, 1'b1, E_OVR | E_CON);
    run(1'b0, 1'b0, E_OVR, 3);
    run(1'b0, 1'b0, E_LCK, 6);
    run(1'b0, 1'b0, E_IDLE, 1);

    cur_test = "async_reset";
    run(1'b1, 1'b0, E_HEAT, 4);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_midrun", outs(), E_IDLE);
    @(negedge clk);
    rst = 1'b0;
    heat_req = 1'b1;
    exp_q.push_back(E_HEAT);
    finish_run(E_HEAT, 7);
    run(1'b0, 1'b0, E_IDLE, 2);

    cur_test = "drain";
    @(negedge clk);
    @(negedge clk);
    check("queue_empty", 5'(exp_q.size()), 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
